mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 4096x8 single-port memory.
- The memory has a combinational write on Write=1 and a tri-stated read on Read=1.
- The block serialises read/write transactions from requesters A and B and drives the memory's Address/Din/Read/Write.
- It samples Dout and returns read data with a one-cycle Ack pulse per requester.

Parameters:
- ADDR_W, 12, memory address width (4096 locations).
- DATA_W, 8, memory data width.
- ACCESS_CYCLES, 1, cycles Read/Write stay asserted per transaction (1..15); read data is sampled on the last one.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- Req_A  in  1  requester A transaction request; held high until Ack_A.
- Wr_A  in  1  A: 1=write, 0=read; sampled at grant.
- Addr_A  in  ADDR_W  A address; sampled at grant.
- Wdata_A  in  DATA_W  A write data; sampled at grant.
- Gnt_A  out  1  A owns the memory (ACCESS and ACK states).
- Ack_A  out  1  one-cycle completion pulse for A.
- Rdata_A  out  DATA_W  A read data; valid with Ack_A, held until A's next read completes.
- Req_B, Wr_B, Addr_B, Wdata_B, Gnt_B, Ack_B, Rdata_B  same as A, for requester B.
- Mem_Address  out  ADDR_W  to memory Address.
- Mem_Din  out  DATA_W  to memory Din.
- Mem_Read  out  1  to memory Read.
- Mem_Write  out  1  to memory Write.
- Mem_Dout  in  DATA_W  from memory Dout; only meaningful while Mem_Read=1.

Behaviour:
- All outputs are registered. On rst:
  - state=IDLE; Gnt_*, Ack_*, Mem_Read, Mem_Write all 0.
  - Mem_Address, Mem_Din, Rdata_A, Rdata_B all 0.
  - last_served=B, so A wins the first tie.
  - A reset mid-transaction aborts it immediately; no Ack is issued.
- FSM states: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - If only one Req is high, grant it. If both are high, grant the requester not equal to last_served.
  - At grant, latch that requester's Wr/Addr/Wdata into Mem_Address/Mem_Din and an internal wr flag.
  - Load cnt=ACCESS_CYCLES-1 and go to ACCESS. Gnt_x rises on entry to ACCESS.
  - If no Req is high, stay in IDLE with all memory strobes 0.
- ACCESS:
  - Exactly one of Mem_Write (wr=1) or Mem_Read (wr=0) is high every cycle.
  - Mem_Address and Mem_Din are stable for the whole state.
  - When cnt==0: for a read, capture Mem_Dout into Rdata_x at that edge. Then go to ACK.
  - Otherwise decrement cnt.
  - Both strobes go to 0 on the edge leaving ACCESS.
- ACK:
  - Ack_x=1 for exactly one cycle; Gnt_x stays 1; strobes are 0.
  - Set last_served=x and go to IDLE. Gnt_x falls on leaving ACK.
- Latency with ACCESS_CYCLES=N: a Req seen in IDLE at cycle t gives ACCESS for cycles t+1..t+N and Ack at cycle t+N+1. A back-to-back transaction starts at the earliest at t+N+2 (IDLE cycle).
- Requests:
  - Deassertion of Req during ACCESS/ACK is ignored; the transaction completes and Ack is still pulsed.
  - Changes on Wr/Addr/Wdata after grant are ignored.
  - Req held high after Ack is treated as a new request in the next IDLE cycle.
- Fairness: with both Req continuously high, grants alternate A,B,A,B...
- Invariants:
  - Mem_Read & Mem_Write never both 1.
  - Gnt_A & Gnt_B never both 1.
  - Mem_Dout is never sampled while Mem_Read=0, because the bus is Z then.
  - Wrap-around is n/a: addresses pass straight through, full ADDR_W range (0..4095).

Test Plan:
- Memory model preloaded with [0]=5, [86]=24, [4065]=60. A reads 86 with N=1 -> Mem_Read high 1 cycle; Ack_A 2 cycles after the Req sample; Rdata_A=24; Gnt_B stays 0.
- B writes 0x3C to address 4095, then B reads 4095 -> one Mem_Write pulse with Mem_Address=4095 and Mem_Din=0x3C; the read returns Rdata_B=0x3C.
- A and B request simultaneously out of reset (A reads 0, B reads 4065) -> A is served first (Rdata_A=5), B next (Rdata_B=60). Both held high for 4 transactions -> grant order A,B,A,B.
- ACCESS_CYCLES=3, A reads 86 -> Mem_Read high exactly 3 cycles; Ack_A at t+4; Rdata_A=24. A drops Req during ACCESS -> Ack_A still pulses.
- rst asserted during ACCESS of a write -> next cycle all outputs are 0, no Ack, and state is IDLE. A subsequent A request is granted normally.
- Throughout all tests, a checker asserts:
  - no simultaneous Mem_Read/Mem_Write or Gnt_A/Gnt_B;
  - Ack width is always exactly 1 cycle;
  - Mem_Address/Mem_Din are stable throughout ACCESS.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin A/B arbiter sequencing one single-port memory; Ack lands ACCESS_CYCLES+1 cycles after the request is sampled.
// Backpressure: each requester holds Req until its Ack; the loser of a tie simply waits in IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req_A,
    input  logic              Wr_A,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [DATA_W-1:0] Wdata_A,
    output logic              Gnt_A,
    output logic              Ack_A,
    output logic [DATA_W-1:0] Rdata_A,
    input  logic              Req_B,
    input  logic              Wr_B,
    input  logic [ADDR_W-1:0] Addr_B,
    input  logic [DATA_W-1:0] Wdata_B,
    output logic              Gnt_B,
    output logic              Ack_B,
    output logic [DATA_W-1:0] Rdata_B,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Din,
    output logic              Mem_Read,
    output logic              Mem_Write,
    input  logic [DATA_W-1:0] Mem_Dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                own_b_q, own_b_d;
    logic                wr_q, wr_d;
    logic                last_b_q, last_b_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   din_d;
    logic                rd_d, wrs_d;
    logic                gnt_a_d, gnt_b_d, ack_a_d, ack_b_d;
    logic [DATA_W-1:0]   rdata_a_d, rdata_b_d;
    logic                pick_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            own_b_q     <= 1'b0;
            wr_q        <= 1'b0;
            last_b_q    <= 1'b1;
            Mem_Address <= '0;
            Mem_Din     <= '0;
            Mem_Read    <= 1'b0;
            Mem_Write   <= 1'b0;
            Gnt_A       <= 1'b0;
            Gnt_B       <= 1'b0;
            Ack_A       <= 1'b0;
            Ack_B       <= 1'b0;
            Rdata_A     <= '0;
            Rdata_B     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_b_q     <= own_b_d;
            wr_q        <= wr_d;
            last_b_q    <= last_b_d;
            Mem_Address <= addr_d;
            Mem_Din     <= din_d;
            Mem_Read    <= rd_d;
            Mem_Write   <= wrs_d;
            Gnt_A       <= gnt_a_d;
            Gnt_B       <= gnt_b_d;
            Ack_A       <= ack_a_d;
            Ack_B       <= ack_b_d;
            Rdata_A     <= rdata_a_d;
            Rdata_B     <= rdata_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_b_d   = own_b_q;
        wr_d      = wr_q;
        last_b_d  = last_b_q;
        addr_d    = Mem_Address;
        din_d     = Mem_Din;
        rd_d      = Mem_Read;
        wrs_d     = Mem_Write;
        gnt_a_d   = Gnt_A;
        gnt_b_d   = Gnt_B;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = Rdata_A;
        rdata_b_d = Rdata_B;
        // On a tie, B wins only if A was served last.
        pick_b    = Req_B & (~Req_A | ~last_b_q);

        case (state_q)
            IDLE: begin
                if (Req_A | Req_B) begin
                    own_b_d = pick_b;
                    wr_d    = pick_b ? Wr_B : Wr_A;
                    addr_d  = pick_b ? Addr_B : Addr_A;
                    din_d   = pick_b ? Wdata_B : Wdata_A;
                    rd_d    = ~(pick_b ? Wr_B : Wr_A);
                    wrs_d   = pick_b ? Wr_B : Wr_A;
                    gnt_a_d = ~pick_b;
                    gnt_b_d = pick_b;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Dout is only driven while Read is high, i.e. on this last access cycle.
                    if (!wr_q) begin
                        if (own_b_q) rdata_b_d = Mem_Dout;
                        else         rdata_a_d = Mem_Dout;
                    end
                    rd_d    = 1'b0;
                    wrs_d   = 1'b0;
                    ack_a_d = ~own_b_q;
                    ack_b_d = own_b_q;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                gnt_a_d  = 1'b0;
                gnt_b_d  = 1'b0;
                last_b_d = own_b_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with ACCESS_CYCLES=1, one with ACCESS_CYCLES=3.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        Req_A = 0, Wr_A = 0, Req_B = 0, Wr_B = 0;
    logic [11:0] Addr_A = 0, Addr_B = 0;
    logic [7:0]  Wdata_A = 0, Wdata_B = 0;
    logic        Gnt_A, Ack_A, Gnt_B, Ack_B, Mem_Read, Mem_Write;
    logic [7:0]  Rdata_A, Rdata_B, Mem_Din, Mem_Dout;
    logic [11:0] Mem_Address;

    logic        Req3_A = 0, Wr3_A = 0, Req3_B = 0, Wr3_B = 0;
    logic [11:0] Addr3_A = 0, Addr3_B = 0;
    logic [7:0]  Wdata3_A = 0, Wdata3_B = 0;
    logic        Gnt3_A, Ack3_A, Gnt3_B, Ack3_B, Mem3_Read, Mem3_Write;
    logic [7:0]  Rdata3_A, Rdata3_B, Mem3_Din, Mem3_Dout;
    logic [11:0] Mem3_Address;

    logic [7:0]  mem1 [0:4095];
    logic [7:0]  mem3 [0:4095];

    // Idle-bus pattern stands in for Z so a wrong-cycle capture is visible.
    assign Mem_Dout  = Mem_Read  ? mem1[Mem_Address]  : 8'hEE;
    assign Mem3_Dout = Mem3_Read ? mem3[Mem3_Address] : 8'hEE;

    int total = 0;
    int bad   = 0;

    logic p_ack_a = 0, p_ack_b = 0, p_strb1 = 0, p3_ack_a = 0, p3_ack_b = 0, p_strb3 = 0;
    logic [19:0] p_ad1 = 0, p_ad3 = 0;

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(8), .ACCESS_CYCLES(1)) u1 (
        .clk(clk), .rst(rst),
        .Req_A(Req_A), .Wr_A(Wr_A), .Addr_A(Addr_A), .Wdata_A(Wdata_A),
        .Gnt_A(Gnt_A), .Ack_A(Ack_A), .Rdata_A(Rdata_A),
        .Req_B(Req_B), .Wr_B(Wr_B), .Addr_B(Addr_B), .Wdata_B(Wdata_B),
        .Gnt_B(Gnt_B), .Ack_B(Ack_B), .Rdata_B(Rdata_B),
        .Mem_Address(Mem_Address), .Mem_Din(Mem_Din), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .Mem_Dout(Mem_Dout)
    );

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(8), .ACCESS_CYCLES(3)) u3 (
        .clk(clk), .rst(rst),
        .Req_A(Req3_A), .Wr_A(Wr3_A), .Addr_A(Addr3_A), .Wdata_A(Wdata3_A),
        .Gnt_A(Gnt3_A), .Ack_A(Ack3_A), .Rdata_A(Rdata3_A),
        .Req_B(Req3_B), .Wr_B(Wr3_B), .Addr_B(Addr3_B), .Wdata_B(Wdata3_B),
        .Gnt_B(Gnt3_B), .Ack_B(Ack3_B), .Rdata_B(Rdata3_B),
        .Mem_Address(Mem3_Address), .Mem_Din(Mem3_Din), .Mem_Read(Mem3_Read),
        .Mem_Write(Mem3_Write), .Mem_Dout(Mem3_Dout)
    );

    // Advance one clock, sample 1 ns later, update memory models and run the invariant checks.
    task automatic tick();
        logic        w1, w3;
        logic [11:0] a1, a3;
        logic [7:0]  d1, d3;
        w1 = Mem_Write;  a1 = Mem_Address;  d1 = Mem_Din;
        w3 = Mem3_Write; a3 = Mem3_Address; d3 = Mem3_Din;
        @(posedge clk);
        #1;
        if (w1) mem1[a1] = d1;
        if (w3) mem3[a3] = d3;

        total++;
        if (((Mem_Read & Mem_Write) | (Gnt_A & Gnt_B)) !== 1'b0) begin
            bad++;
            $display("FAIL excl1: rd=%0b wr=%0b gA=%0b gB=%0b, want no pair high", Mem_Read, Mem_Write, Gnt_A, Gnt_B);
        end
        total++;
        if (((Ack_A & p_ack_a) | (Ack_B & p_ack_b)) !== 1'b0) begin
            bad++;
            $display("FAIL ackw1: ack A/B held 2 cycles, want 1-cycle pulse");
        end
        total++;
        if (((Mem_Read | Mem_Write) & p_strb1 & ({Mem_Address, Mem_Din} != p_ad1)) !== 1'b0) begin
            bad++;
            $display("FAIL stable1: addr/din=%05h was %05h during access", {Mem_Address, Mem_Din}, p_ad1);
        end
        total++;
        if (((Mem3_Read & Mem3_Write) | (Gnt3_A & Gnt3_B)) !== 1'b0) begin
            bad++;
            $display("FAIL excl3: rd=%0b wr=%0b gA=%0b gB=%0b, want no pair high", Mem3_Read, Mem3_Write, Gnt3_A, Gnt3_B);
        end
        total++;
        if (((Ack3_A & p3_ack_a) | (Ack3_B & p3_ack_b)) !== 1'b0) begin
            bad++;
            $display("FAIL ackw3: ack A/B held 2 cycles, want 1-cycle pulse");
        end
        total++;
        if (((Mem3_Read | Mem3_Write) & p_strb3 & ({Mem3_Address, Mem3_Din} != p_ad3)) !== 1'b0) begin
            bad++;
            $display("FAIL stable3: addr/din=%05h was %05h during access", {Mem3_Address, Mem3_Din}, p_ad3);
        end
        p_ack_a = Ack_A;   p_ack_b = Ack_B;   p_strb1 = Mem_Read | Mem_Write;   p_ad1 = {Mem_Address, Mem_Din};
        p3_ack_a = Ack3_A; p3_ack_b = Ack3_B; p_strb3 = Mem3_Read | Mem3_Write; p_ad3 = {Mem3_Address, Mem3_Din};
    endtask

    // Run one transaction on u1 from IDLE and return what was observed; leaves the DUT back in IDLE.
    task automatic do_txn(input bit is_b, input bit wr, input logic [11:0] addr, input logic [7:0] wd,
                          output int lat, output int rd_cyc, output int wr_cyc,
                          output logic [11:0] seen_addr, output logic [7:0] seen_din,
                          output logic [7:0] rdata, output bit other_gnt);
        bit done;
        done = 0; lat = 0; rd_cyc = 0; wr_cyc = 0; other_gnt = 0;
        seen_addr = '0; seen_din = '0;
        if (is_b) begin Req_B = 1; Wr_B = wr; Addr_B = addr; Wdata_B = wd; end
        else      begin Req_A = 1; Wr_A = wr; Addr_A = addr; Wdata_A = wd; end
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (Mem_Read)  rd_cyc++;
            if (Mem_Write) wr_cyc++;
            if (Mem_Read | Mem_Write) begin seen_addr = Mem_Address; seen_din = Mem_Din; end
            if (is_b ? Gnt_A : Gnt_B) other_gnt = 1;
            if (is_b ? Ack_B : Ack_A) done = 1;
        end
        if (!done) lat = -1;
        rdata = is_b ? Rdata_B : Rdata_A;
        Req_A = 0; Req_B = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        total++;
        if ({Gnt_A, Gnt_B, Ack_A, Ack_B, Mem_Read, Mem_Write} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl1: got %06b want 000000", {Gnt_A, Gnt_B, Ack_A, Ack_B, Mem_Read, Mem_Write});
        end
        total++;
        if ({Mem_Address, Mem_Din, Rdata_A, Rdata_B} !== 36'h0) begin
            bad++; $display("FAIL reset_dat1: got %09h want 0", {Mem_Address, Mem_Din, Rdata_A, Rdata_B});
        end
        total++;
        if ({Gnt3_A, Gnt3_B, Ack3_A, Ack3_B, Mem3_Read, Mem3_Write, Mem3_Address, Rdata3_A} !== 26'h0) begin
            bad++; $display("FAIL reset_u3: outputs not all zero");
        end
        Req_A = 1;
        tick();
        total++;
        if (Gnt_A !== 1'b0) begin
            bad++; $display("FAIL reset_hold: Gnt_A=%0b under reset, want 0", Gnt_A);
        end
        Req_A = 0;
        rst = 0;
        tick();
    endtask

    task automatic test_single_read();
        Req_A = 1; Wr_A = 0; Addr_A = 12'd86;
        tick();
        total++;
        if ({Gnt_A, Gnt_B, Mem_Read, Mem_Write, Ack_A, Mem_Address} !== {5'b10100, 12'd86}) begin
            bad++; $display("FAIL rdA_access: gA gB rd wr ack addr = %0b%0b%0b%0b%0b %0d, want 10100 86",
                            Gnt_A, Gnt_B, Mem_Read, Mem_Write, Ack_A, Mem_Address);
        end
        Addr_A = 12'd0;  // post-grant change must be ignored
        tick();
        total++;
        if ({Ack_A, Gnt_A, Gnt_B, Mem_Read, Rdata_A} !== {4'b1100, 8'd24}) begin
            bad++; $display("FAIL rdA_ack: ack gA gB rd = %0b%0b%0b%0b rdata=%0d, want 1100 24",
                            Ack_A, Gnt_A, Gnt_B, Mem_Read, Rdata_A);
        end
        Req_A = 0;
        tick();
        total++;
        if ({Ack_A, Gnt_A, Mem_Read, Rdata_A} !== {3'b000, 8'd24}) begin
            bad++; $display("FAIL rdA_idle: ack gA rd = %0b%0b%0b rdata=%0d, want 000 24", Ack_A, Gnt_A, Mem_Read, Rdata_A);
        end
    endtask

    task automatic test_write_read_b();
        int lat, rdc, wrc;
        logic [11:0] sa;
        logic [7:0] sd, rd;
        bit og;
        do_txn(1, 1, 12'd4095, 8'h3C, lat, rdc, wrc, sa, sd, rd, og);
        total++;
        if ({lat[3:0], rdc[3:0], wrc[3:0], og} !== {4'd2, 4'd0, 4'd1, 1'b0} || lat < 0) begin
            bad++; $display("FAIL wrB_pulse: lat=%0d rdc=%0d wrc=%0d gA=%0b, want 2 0 1 0", lat, rdc, wrc, og);
        end
        total++;
        if ({sa, sd} !== {12'd4095, 8'h3C}) begin
            bad++; $display("FAIL wrB_bus: addr=%0d din=%02h, want 4095 3c", sa, sd);
        end
        do_txn(1, 0, 12'd4095, 8'h00, lat, rdc, wrc, sa, sd, rd, og);
        total++;
        if ({lat[3:0], rdc[3:0], wrc[3:0], og} !== {4'd2, 4'd1, 4'd0, 1'b0} || lat < 0) begin
            bad++; $display("FAIL rdB_pulse: lat=%0d rdc=%0d wrc=%0d gA=%0b, want 2 1 0 0", lat, rdc, wrc, og);
        end
        total++;
        if (rd !== 8'h3C) begin
            bad++; $display("FAIL rdB_data: got %02h want 3c", rd);
        end
    endtask

    task automatic test_tie_fair();
        int order [4];
        int exp_order [4] = '{0, 1, 0, 1};
        int n, cyc;
        logic [7:0] first_a, first_b;
        rst = 1; tick(); rst = 0;
        n = 0; cyc = 0; first_a = 8'hFF; first_b = 8'hFF;
        for (int i = 0; i < 4; i++) order[i] = 9;
        Req_A = 1; Wr_A = 0; Addr_A = 12'd0;
        Req_B = 1; Wr_B = 0; Addr_B = 12'd4065;
        while (n < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (Ack_A) begin order[n] = 0; if (first_a == 8'hFF) first_a = Rdata_A; n++; end
            if (Ack_B) begin order[n] = 1; if (first_b == 8'hFF) first_b = Rdata_B; n++; end
        end
        Req_A = 0; Req_B = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (order[i] !== exp_order[i]) begin
                bad++; $display("FAIL fair_order[%0d]: got %0d want %0d (0=A 1=B)", i, order[i], exp_order[i]);
            end
        end
        total++;
        if (cyc !== 11) begin
            bad++; $display("FAIL fair_b2b: 4th ack at cycle %0d, want 11", cyc);
        end
        total++;
        if ({first_a, first_b} !== {8'd5, 8'd60}) begin
            bad++; $display("FAIL fair_data: A=%0d B=%0d, want 5 60", first_a, first_b);
        end
        total++;
        if ({Gnt_A, Gnt_B, Ack_A, Ack_B} !== 4'b0) begin
            bad++; $display("FAIL fair_idle: gA gB aA aB = %0b%0b%0b%0b want 0000", Gnt_A, Gnt_B, Ack_A, Ack_B);
        end
    endtask

    task automatic test_multicycle();
        int lat, rdc;
        bit done;
        lat = 0; rdc = 0; done = 0;
        Req3_A = 1; Wr3_A = 0; Addr3_A = 12'd86;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (Mem3_Read) rdc++;
            if (lat == 1) Req3_A = 0;  // requester withdraws mid-access
            if (Ack3_A) done = 1;
        end
        total++;
        if (lat !== 4 || !done) begin
            bad++; $display("FAIL n3_latency: ack after %0d cycles (done=%0b), want 4", lat, done);
        end
        total++;
        if (rdc !== 3) begin
            bad++; $display("FAIL n3_readcyc: Mem_Read high %0d cycles, want 3", rdc);
        end
        total++;
        if ({Rdata3_A, Gnt3_A} !== {8'd24, 1'b1}) begin
            bad++; $display("FAIL n3_data: rdata=%0d gnt=%0b, want 24 1", Rdata3_A, Gnt3_A);
        end
        tick();
        total++;
        if ({Ack3_A, Gnt3_A, Mem3_Read} !== 3'b000) begin
            bad++; $display("FAIL n3_after: ack gnt rd = %0b%0b%0b want 000", Ack3_A, Gnt3_A, Mem3_Read);
        end
    endtask

    task automatic test_reset_mid();
        int lat, rdc, wrc;
        logic [11:0] sa;
        logic [7:0] sd, rd;
        bit og;
        Req_A = 1; Wr_A = 1; Addr_A = 12'd200; Wdata_A = 8'h77;
        tick();
        total++;
        if ({Gnt_A, Mem_Write, Mem_Read} !== 3'b110) begin
            bad++; $display("FAIL mid_access: gA wr rd = %0b%0b%0b want 110", Gnt_A, Mem_Write, Mem_Read);
        end
        rst = 1; Req_A = 0;
        tick();
        total++;
        if ({Gnt_A, Gnt_B, Ack_A, Ack_B, Mem_Read, Mem_Write} !== 6'b0) begin
            bad++; $display("FAIL mid_ctl: got %06b want 000000", {Gnt_A, Gnt_B, Ack_A, Ack_B, Mem_Read, Mem_Write});
        end
        total++;
        if ({Mem_Address, Mem_Din, Rdata_A, Rdata_B} !== 36'h0) begin
            bad++; $display("FAIL mid_dat: got %09h want 0", {Mem_Address, Mem_Din, Rdata_A, Rdata_B});
        end
        rst = 0;
        tick();
        total++;
        if ({Ack_A, Gnt_A, Mem_Write} !== 3'b000) begin
            bad++; $display("FAIL mid_noack: ack gnt wr = %0b%0b%0b want 000", Ack_A, Gnt_A, Mem_Write);
        end
        do_txn(0, 0, 12'd86, 8'h00, lat, rdc, wrc, sa, sd, rd, og);
        total++;
        if ({lat[3:0], rdc[3:0], rd} !== {4'd2, 4'd1, 8'd24} || lat < 0) begin
            bad++; $display("FAIL mid_resume: lat=%0d rdc=%0d rdata=%0d, want 2 1 24", lat, rdc, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[0] = 8'd5; mem1[86] = 8'd24; mem1[4065] = 8'd60;
        mem3[0] = 8'd5; mem3[86] = 8'd24; mem3[4065] = 8'd60;

        test_reset();
        test_single_read();
        test_write_read_b();
        test_tie_fair();
        test_multicycle();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
